adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one W-bit adder through a 2-stage pipeline
//
// Purpose:
//   NREQ requesters compete for a single shared W-bit adder. A round-robin
//   arbiter accepts at most one operation per cycle into the operand stage (S1).
//   The adder is driven combinationally from S1, and its result is registered
//   into the result stage (S2), which presents the response to the consumer.
//   A saturating counter tallies delivered responses that carry an overflow flag.
//
// Ports (adder_arbiter):
//   clk          - single clock, rising edge
//   rst          - synchronous active-high reset
//   req_valid    - [NREQ]   per-requester operation valid
//   req_a        - [NREQ*W] operand A, requester i in bits [i*W +: W]
//   req_b        - [NREQ*W] operand B, same packing as req_a
//   req_cin      - [NREQ]   per-requester carry-in
//   req_ready    - [NREQ]   one-hot accept (all-zero when nothing is accepted)
//   resp_valid   - result valid
//   resp_ready   - consumer accepts result
//   resp_id      - [clog2(NREQ)] originating requester
//   resp_s       - [W] sum
//   resp_cout    - carry-out
//   resp_pos_ovf - signed positive overflow
//   resp_neg_ovf - signed negative overflow
//   ovf_cnt      - [16] saturating count of delivered overflow results
//
// Ports (adder_arbiter_adder):
//   a, b, cin    - operands and carry-in
//   s, cout      - W-bit sum and carry-out
//   pos_overflow - two non-negative operands produced a negative sum
//   neg_overflow - two negative operands produced a non-negative sum

module adder_arbiter_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         pos_overflow,
  output logic         neg_overflow
);

  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign s    = sum[W-1:0];
  assign cout = sum[W];

  // Signed overflow is only possible when both operands share a sign and the
  // result's sign differs from it; the carry-in cannot change that rule.
  assign pos_overflow = ~a[W-1] & ~b[W-1] &  s[W-1];
  assign neg_overflow =  a[W-1] &  b[W-1] & ~s[W-1];

endmodule

module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_a,
  input  logic [NREQ*W-1:0]        req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic [NREQ-1:0]          req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [W-1:0]             resp_s,
  output logic                     resp_cout,
  output logic                     resp_pos_ovf,
  output logic                     resp_neg_ovf,
  output logic [15:0]              ovf_cnt
);

  localparam int IDW  = $clog2(NREQ);
  localparam int IDX1 = IDW + 1;
  localparam logic [IDW:0]    NREQ_W   = IDX1'(NREQ);
  localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  // Arbitration state
  logic [IDW-1:0]  ptr;

  // S1: operand stage
  logic            s1_valid;
  logic [W-1:0]    s1_a;
  logic [W-1:0]    s1_b;
  logic            s1_cin;
  logic [IDW-1:0]  s1_id;

  // S2: result stage
  logic            s2_valid;
  logic [W-1:0]    s2_s;
  logic            s2_cout;
  logic            s2_pos;
  logic            s2_neg;
  logic [IDW-1:0]  s2_id;

  // Shared adder outputs
  logic [W-1:0]    add_s;
  logic            add_cout;
  logic            add_pos;
  logic            add_neg;

  // Pipeline control
  logic            s2_load;
  logic            s1_accept;
  logic            resp_fire;

  // Arbiter datapath
  logic [NREQ-1:0] rot;
  logic            found;
  logic [IDW:0]    off;
  logic [IDW:0]    idx_sum;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] grant;
  logic            xfer;

  adder_arbiter_adder #(.W(W)) u_adder (
    .a            (s1_a),
    .b            (s1_b),
    .cin          (s1_cin),
    .s            (add_s),
    .cout         (add_cout),
    .pos_overflow (add_pos),
    .neg_overflow (add_neg)
  );

  // S1 drains into S2 whenever S2 is empty or its response is being taken;
  // S1 can take a new operation when empty or draining in the same cycle.
  assign s2_load   = s1_valid & (~s2_valid | resp_ready);
  assign s1_accept = ~s1_valid | s2_load;
  assign resp_fire = s2_valid & resp_ready;

  // Round-robin winner: rotate the valid vector so the pointer sits at bit 0,
  // take the lowest set bit, then map the offset back to a requester index.
  always_comb begin
    rot     = NREQ'({req_valid, req_valid} >> ptr);
    found   = 1'b0;
    off     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDX1'(k);
      end
    end
    idx_sum = {1'b0, ptr} + off;
    if (idx_sum >= NREQ_W) begin
      idx_sum = idx_sum - NREQ_W;
    end
    win_id  = idx_sum[IDW-1:0];
  end

  // Grant is suppressed during reset so nothing is handed out in a cycle
  // whose capture edge is going to be discarded.
  always_comb begin
    grant = '0;
    if (!rst && s1_accept && found) begin
      grant = ONE_HOT0 << win_id;
    end
  end

  assign xfer      = |grant;
  assign req_ready = grant;

  // Pointer and S1
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_id    <= '0;
    end else begin
      if (xfer) begin
        s1_valid <= 1'b1;
        s1_a     <= req_a[int'(win_id) * W +: W];
        s1_b     <= req_b[int'(win_id) * W +: W];
        s1_cin   <= req_cin[win_id];
        s1_id    <= win_id;
        ptr      <= (win_id == LAST_ID) ? '0 : win_id + 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2: result register; holds its contents while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_s     <= '0;
      s2_cout  <= 1'b0;
      s2_pos   <= 1'b0;
      s2_neg   <= 1'b0;
      s2_id    <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_s     <= add_s;
        s2_cout  <= add_cout;
        s2_pos   <= add_pos;
        s2_neg   <= add_neg;
        s2_id    <= s1_id;
      end else if (resp_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Overflow counter counts delivered responses only, and sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt <= '0;
    end else if (resp_fire && (s2_pos || s2_neg) && (ovf_cnt != 16'hFFFF)) begin
      ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  assign resp_valid   = s2_valid;
  assign resp_id      = s2_id;
  assign resp_s       = s2_s;
  assign resp_cout    = s2_cout;
  assign resp_pos_ovf = s2_pos;
  assign resp_neg_ovf = s2_neg;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter

module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_s;
  logic              resp_cout;
  logic              resp_pos_ovf;
  logic              resp_neg_ovf;
  logic [15:0]       ovf_cnt;

  always #5 clk = ~clk;

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_s       (resp_s),
    .resp_cout    (resp_cout),
    .resp_pos_ovf (resp_pos_ovf),
    .resp_neg_ovf (resp_neg_ovf),
    .ovf_cnt      (ovf_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
    logic        pos;
    logic        neg;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] s;
    logic        cout;
    logic        pos;
    logic        neg;
    int          acc;
  } exp_t;

  vec_t vecs [7];
  exp_t q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic cin);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_cin[i]       = cin;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_req();
    tick();
    rst = 1'b0;
  endtask

  // Reference: sum modulo 2^W and signed overflow from true signed arithmetic
  function automatic exp_t ref_add(input int id, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input int cyc);
    exp_t r;
    longint unsigned u;
    longint sg;
    u  = longint'(a) + longint'(b) + longint'(cin);
    sg = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    r.id   = id;
    r.s    = u[31:0];
    r.cout = u[32];
    r.pos  = (sg > SMAX);
    r.neg  = (sg < SMIN);
    r.acc  = cyc;
    return r;
  endfunction

  initial begin
    int exp_ovf;
    int ptr_m;
    int m_ovf;
    int last_pop;
    int hs;
    int nresp;
    bit pend [NREQ];
    logic [NREQ-1:0] exp_grant;

    vecs[0] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2, 32'hFFFFFFE2, 32'h00000028, 1'b1, 32'h0000000B, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2, 32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b1};

    // ---------------- reset state ----------------
    rst        = 1'b1;
    resp_ready = 1'b1;
    clr_req();
    req_valid  = '1;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    chk("rst_resp_s", resp_s, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_flags", {resp_cout, resp_pos_ovf, resp_neg_ovf}, 0);
    tick();
    rst = 1'b0;
    clr_req();

    // ---------------- table-driven single operations ----------------
    exp_ovf = 0;
    for (int v = 0; v < 7; v++) begin
      clr_req();
      set_req(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].cin);
      @(negedge clk);
      chk("tbl_grant", req_ready, 64'(1) << vecs[v].id);
      tick();
      clr_req();
      @(negedge clk);
      chk("tbl_n1_resp_valid", resp_valid, 0);
      tick();
      @(negedge clk);
      chk("tbl_n2_resp_valid", resp_valid, 1);
      chk("tbl_resp_id", resp_id, vecs[v].id);
      chk("tbl_resp_s", resp_s, vecs[v].s);
      chk("tbl_flags", {resp_cout, resp_pos_ovf, resp_neg_ovf},
          {vecs[v].cout, vecs[v].pos, vecs[v].neg});
      tick();
      if (vecs[v].pos || vecs[v].neg) exp_ovf++;
      chk("tbl_ovf_cnt", ovf_cnt, exp_ovf);
      chk("tbl_after_resp_valid", resp_valid, 0);
    end

    // Last grant went to requester 3, so 0 must win over 3 now
    set_req(0, 32'd1, 32'd2, 1'b0);
    set_req(3, 32'd5, 32'd5, 1'b0);
    @(negedge clk);
    chk("ptr_wrap_grant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("ptr_wrap_next_grant", req_ready, 4'b1000);
    tick();
    clr_req();
    @(negedge clk);
    chk("ptr_wrap_resp_id0", resp_id, 0);
    chk("ptr_wrap_resp_s0", resp_s, 3);
    tick();
    @(negedge clk);
    chk("ptr_wrap_resp_id3", resp_id, 3);
    chk("ptr_wrap_resp_s3", resp_s, 10);
    tick();

    // ---------------- round-robin sequence ----------------
    do_reset();
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i), 32'd10, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) chk("rr_grant", req_ready, 64'(1) << (k % 4));
      if (k >= 2) begin
        chk("rr_resp_valid", resp_valid, 1);
        chk("rr_resp_s", resp_s, 10 + ((k - 2) % 4));
        chk("rr_resp_id", resp_id, (k - 2) % 4);
      end
      tick();
    end

    // ---------------- backpressure ----------------
    do_reset();
    resp_ready = 1'b0;
    set_req(2, 32'hFFFFFFE2, 32'd40, 1'b1);
    @(negedge clk);
    chk("bp_grant2", req_ready, 4'b0100);
    tick();
    clr_req();
    set_req(1, 32'd5, 32'd7, 1'b0);
    @(negedge clk);
    chk("bp_grant1", req_ready, 4'b0010);
    tick();
    clr_req();
    set_req(0, 32'd1, 32'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", req_ready, 0);
      chk("bp_hold_valid", resp_valid, 1);
      chk("bp_hold_s", resp_s, 32'hB);
      chk("bp_hold_id", resp_id, 2);
      chk("bp_hold_flags", {resp_cout, resp_pos_ovf, resp_neg_ovf}, 3'b100);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_resp_id", resp_id, 2);
    chk("bp_rel_resp_s", resp_s, 32'hB);
    chk("bp_rel_grant0", req_ready, 4'b0001);
    tick();
    clr_req();
    @(negedge clk);
    chk("bp_second_valid", resp_valid, 1);
    chk("bp_second_id", resp_id, 1);
    chk("bp_second_s", resp_s, 12);
    tick();
    @(negedge clk);
    chk("bp_third_valid", resp_valid, 1);
    chk("bp_third_id", resp_id, 0);
    chk("bp_third_s", resp_s, 3);
    tick();
    @(negedge clk);
    chk("bp_drained", resp_valid, 0);
    tick();

    // ---------------- reset mid-operation ----------------
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 32'h7FFFFFFF, 32'd1, 1'b0);
    tick();
    clr_req();
    tick();
    tick();
    chk("mid_ovf_before", ovf_cnt, 1);
    resp_ready = 1'b0;
    set_req(1, 32'h7FFFFFFF, 32'd1, 1'b0);
    tick();
    clr_req();
    set_req(2, 32'h80000000, 32'h80000000, 1'b0);
    tick();
    clr_req();
    @(negedge clk);
    chk("mid_s2_full", resp_valid, 1);
    chk("mid_stalled", req_ready, 0);
    tick();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    clr_req();
    chk("mid_resp_valid", resp_valid, 0);
    chk("mid_ovf_cnt", ovf_cnt, 0);
    chk("mid_resp_s", resp_s, 0);
    resp_ready = 1'b1;
    req_valid  = '1;
    @(negedge clk);
    chk("mid_ptr_grant", req_ready, 4'b0001);
    tick();
    clr_req();
    nresp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        nresp++;
        chk("mid_only_fresh_id", resp_id, 0);
      end
      tick();
    end
    chk("mid_resp_count", nresp, 1);
    chk("mid_ovf_after", ovf_cnt, 0);

    // ---------------- randomized against reference model ----------------
    do_reset();
    ptr_m    = 0;
    m_ovf    = 0;
    last_pop = -100;
    q.delete();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 3100; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && cyc < 3000 && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          if ($urandom_range(0, 3) == 0)
            set_req(i, 32'h7FFFFFF0 + $urandom_range(0, 31), 32'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)));
          else if ($urandom_range(0, 3) == 0)
            set_req(i, 32'h80000000 + $urandom_range(0, 15), 32'hFFFFFFF0 + $urandom_range(0, 15),
                    1'($urandom_range(0, 1)));
          else
            set_req(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        req_valid[i] = pend[i];
      end
      resp_ready = (cyc >= 3000) ? 1'b1 : ($urandom_range(0, 9) < 7);
      @(negedge clk);

      exp_grant = '0;
      if (req_valid != 0 && (q.size() < 2 || resp_ready)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (exp_grant == 0 && req_valid[(ptr_m + k) % NREQ])
            exp_grant = NREQ'(1) << ((ptr_m + k) % NREQ);
        end
      end
      chk("rnd_grant", req_ready, exp_grant);
      chk("rnd_ovf_cnt", ovf_cnt, m_ovf);

      if (q.size() == 0)
        chk("rnd_resp_valid", resp_valid, 0);
      else
        chk("rnd_resp_valid", resp_valid,
            (cyc >= ((q[0].acc + 2 > last_pop + 1) ? q[0].acc + 2 : last_pop + 1)));

      if (resp_valid && q.size() > 0) begin
        chk("rnd_resp", {resp_id, resp_cout, resp_pos_ovf, resp_neg_ovf, resp_s},
            {2'(q[0].id), q[0].cout, q[0].pos, q[0].neg, q[0].s});
        if (resp_ready) begin
          if ((q[0].pos || q[0].neg) && m_ovf < 65535) m_ovf++;
          void'(q.pop_front());
          last_pop = cyc;
        end
      end

      for (int i = 0; i < NREQ; i++) begin
        if (exp_grant[i]) begin
          q.push_back(ref_add(i, req_a[i*W +: W], req_b[i*W +: W], req_cin[i], cyc));
          pend[i] = 1'b0;
          ptr_m   = (i + 1) % NREQ;
        end
      end
      tick();
    end
    chk("rnd_drain_queue", q.size(), 0);
    clr_req();

    // ---------------- ovf_cnt saturation ----------------
    do_reset();
    resp_ready = 1'b1;
    set_req(0, 32'h7FFFFFFF, 32'd1, 1'b0);
    hs = 0;
    for (int c = 0; c < 70000 && hs < 65537; c++) begin
      @(negedge clk);
      if (hs == 65534) chk("sat_below", ovf_cnt, 16'hFFFE);
      if (hs == 65535) chk("sat_reach", ovf_cnt, 16'hFFFF);
      if (hs == 65536) chk("sat_hold", ovf_cnt, 16'hFFFF);
      if (resp_valid && resp_ready) hs++;
      tick();
    end
    chk("sat_handshakes", hs, 65537);
    chk("sat_final", ovf_cnt, 16'hFFFF);
    clr_req();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
